tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//  Multi-channel timebase controller: CHANNELS independent programmable-period
//  counters, each issuing a one-cycle tick enable for downstream logic.
//  Single-clock replacement for fabric clock division. Each channel's period
//  is changed at run time through a valid/ready config port.
//  An active channel picks up a new period only at its own period boundary,
//  so tick spacing never glitches.
// PARAMETERS
//  CHANNELS  4   number of independent tick channels (>=1)
//  WIDTH     16  period/counter width; legal period 1..2**WIDTH-1
// PORTS
//  clock       in   1                     system clock; all state on posedge
//  reset       in   1                     asynchronous, active-high reset
//  cfg_valid   in   1                     config write request
//  cfg_ready   out  1                     config write can be accepted (comb.)
//  cfg_chan    in   $clog2(CHANNELS)      target channel (min width 1)
//  cfg_period  in   WIDTH                 new period P in clock cycles
//  cfg_enable  in   1                     1 = run channel, 0 = stop channel
//  tick        out  CHANNELS              per-channel one-cycle tick enable
//  active      out  CHANNELS              channel running
//  pending     out  CHANNELS              period update waiting for boundary
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: count=0, period=0, shadow=0, active=0, pending=0 on all channels.
//   Outputs tick=0, active=0, pending=0 and cfg_ready=1 immediately,
//   independent of clock. Reset mid-operation discards all state.
//  Per-channel state:
//   - count[WIDTH]: counts 0..period-1, then wraps to 0.
//   - period[WIDTH]: current period.
//   - shadow[WIDTH]: waiting period value.
//   - active, pending: 1-bit flags.
//  Tick generation:
//   - tick[i] = active[i] & (count[i]==period[i]-1). It is decoded from
//     registers, with no extra register stage.
//   - Wrap edge: posedge where tick[i]=1.
//  Handshake:
//   - accept = cfg_valid & cfg_ready.
//   - cfg_ready = ~pending[cfg_chan]. A second write to a channel is held off
//     until that channel's update is applied or cancelled.
//   - cfg_chan >= CHANNELS: cfg_ready=1; the write is accepted and dropped.
//  Apply rules, evaluated at the accepting edge:
//   - stop (cfg_enable=0 or cfg_period=0): immediate at this edge.
//     active<=0, count<=0, pending<=0. tick is 0 from the next cycle.
//   - start, channel inactive: immediate at this edge.
//     period<=P, count<=0, active<=1.
//   - start, active, same edge is the wrap edge: applied directly at this edge.
//     period<=P, count<=0, pending stays 0.
//   - start, active, otherwise: shadow<=P, pending<=1. The current period
//     completes with the old P.
//  Pending update: at the wrap edge, period<=shadow, count<=0, pending<=0.
//  Tick timing after apply: first tick in the P-th cycle after the apply edge,
//   then every P cycles. P=1 gives tick=1 every cycle.
//  Counter width: count never exceeds period-1, so there is no WIDTH overflow.
//   period=2**WIDTH-1 is legal.
//  Non-target channels are unaffected by any write. All channels run
//   concurrently, with no arbitration between them.
// TESTING
//  T1 Reset. Write ch0 P=4, en=1, accepted at edge 0 -> tick[0]=1 in cycles
//     4,8,12; active[0]=1; other ticks stay 0.
//  T2 Write ch2 P=1 -> tick[2]=1 every cycle from cycle 1.
//     Then write P=0 -> tick[2]=0 from the next cycle; active[2]=0.
//  T3 ch1 running P=5. Write P=3 when count=1 -> pending[1]=1 and cfg_ready=0
//     for ch1. Tick 3 cycles later at the old boundary. Then pending=0 and
//     ticks every 3 cycles.
//  T4 ch1 P=5. Write P=2 accepted on a wrap edge -> pending[1] never set.
//     Next ticks 2 and 4 cycles later.
//  T5 ch3 with pending update. Write en=0 to ch3 while cfg_ready=0 -> write is
//     held off. After the update is applied, the en=0 write is accepted and
//     tick[3] stops.
//  T6 Assert reset asynchronously mid-period, between clock edges ->
//     tick/active/pending = 0 at once. After release, no ticks until new
//     writes; T1 timing is reproduced.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: per-channel programmable-period tick enables with glitch-free
// run-time period updates applied at each channel's own period boundary.
module tick_scheduler #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CW-1:0]       cfg_chan_i,
  input  logic [WIDTH-1:0]    cfg_period_i,
  input  logic                cfg_enable_i,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] active_o,
  output logic [CHANNELS-1:0] pending_o
);
  logic [CHANNELS-1:0] sel;
  logic stop;
  // an out-of-range channel selects nothing, so it is always ready and dropped
  assign cfg_ready_o = ~|(pending_o & sel);
  assign stop = ~cfg_enable_i | (cfg_period_i == '0);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] count_q, count_d, period_q, period_d, shadow_q, shadow_d;
    logic active_q, active_d, pending_q, pending_d, wr, wrap, imm, defer;
    assign sel[g] = cfg_chan_i == CW'(g);
    assign wrap = active_q & (count_q == period_q - WIDTH'(1));
    assign wr = cfg_valid_i & cfg_ready_o & sel[g];
    // a write is immediate unless it would cut a running period short
    assign imm = wr & (stop | ~active_q | wrap);
    assign defer = wr & ~imm;
    assign tick_o[g] = wrap;
    assign active_o[g] = active_q;
    assign pending_o[g] = pending_q;
    always_comb begin
      count_d = (imm | wrap) ? '0 : active_q ? count_q + WIDTH'(1) : count_q;
      active_d = imm ? ~stop : active_q;
      period_d = (imm & ~stop) ? cfg_period_i : (wrap & pending_q) ? shadow_q : period_q;
      shadow_d = defer ? cfg_period_i : shadow_q;
      pending_d = defer | (pending_q & ~wrap & ~imm);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count_q <= '0;
        period_q <= '0;
        shadow_q <= '0;
        active_q <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        count_q <= count_d;
        period_q <= period_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
        pending_q <= pending_d;
      end
    end
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed checks of tick spacing, deferred period updates,
// handshake hold-off and asynchronous reset.
module tb_tick_scheduler;
  logic clk_i = 1'b0;
  logic rst_i, cfg_valid_i, cfg_ready_o, cfg_enable_i;
  logic [1:0] cfg_chan_i;
  logic [15:0] cfg_period_i;
  logic [3:0] tick_o, active_o, pending_o;
  int checks = 0;
  int failures = 0;

  tick_scheduler #(.CHANNELS(4), .WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_chan_i(cfg_chan_i), .cfg_period_i(cfg_period_i), .cfg_enable_i(cfg_enable_i),
    .tick_o(tick_o), .active_o(active_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] c, input logic [15:0] p, input logic e);
    cfg_chan_i = c;
    cfg_period_i = p;
    cfg_enable_i = e;
    cfg_valid_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_chan_i = '0;
    cfg_period_i = '0;
    cfg_enable_i = 1'b0;
    #2;
    chk("rst_tick", tick_o, 4'h0);
    chk("rst_active", active_o, 4'h0);
    chk("rst_pending", pending_o, 4'h0);
    chk("rst_ready", cfg_ready_o, 1'b1);
    #10 rst_i = 1'b0;
    // T1: ch0 P=4, ticks after the 3rd, 7th, 11th edge following the apply edge
    wr(2'd0, 16'd4, 1'b1);
    chk("t1_active", active_o, 4'b0001);
    chk("t1_tick0", tick_o, 4'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t1_tick_k%0d", k), tick_o, (k % 4 == 3) ? 4'b0001 : 4'b0000);
    end
    wr(2'd0, 16'd0, 1'b1);
    chk("t1_stop_active", active_o, 4'h0);
    chk("t1_stop_tick", tick_o, 4'h0);
    // T2: ch2 P=1 ticks every cycle, then P=0 stops it
    wr(2'd2, 16'd1, 1'b1);
    chk("t2_first", tick_o, 4'b0100);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t2_tick_k%0d", k), tick_o, 4'b0100);
    end
    wr(2'd2, 16'd0, 1'b1);
    chk("t2_stop_tick", tick_o, 4'h0);
    chk("t2_stop_active", active_o, 4'h0);
    // T3: ch1 P=5, write P=3 at count=1 -> deferred to the old boundary
    wr(2'd1, 16'd5, 1'b1);
    step();
    wr(2'd1, 16'd3, 1'b1);
    chk("t3_pending", pending_o, 4'b0010);
    cfg_chan_i = 2'd1;
    #1;
    chk("t3_ready_ch1", cfg_ready_o, 1'b0);
    cfg_chan_i = 2'd0;
    #1;
    chk("t3_ready_ch0", cfg_ready_o, 1'b1);
    step();
    chk("t3_c3", tick_o, 4'h0);
    step();
    chk("t3_old_boundary", tick_o, 4'b0010);
    step();
    chk("t3_applied_pending", pending_o, 4'h0);
    chk("t3_applied_tick", tick_o, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t3_tick_k%0d", k), tick_o, (k % 3 == 2) ? 4'b0010 : 4'b0000);
    end
    // T4: ch1 P=5, write P=2 on the wrap edge -> applied directly
    wr(2'd1, 16'd0, 1'b0);
    chk("t4_stopped", active_o, 4'h0);
    wr(2'd1, 16'd5, 1'b1);
    for (int k = 1; k <= 4; k++) step();
    chk("t4_wrap_tick", tick_o, 4'b0010);
    wr(2'd1, 16'd2, 1'b1);
    chk("t4_no_pending", pending_o, 4'h0);
    chk("t4_after_apply", tick_o, 4'h0);
    step();
    chk("t4_tick2", tick_o, 4'b0010);
    step();
    chk("t4_gap", tick_o, 4'h0);
    step();
    chk("t4_tick4", tick_o, 4'b0010);
    // T5: ch3 stop write held off while an update is pending
    wr(2'd3, 16'd4, 1'b1);
    step();
    wr(2'd3, 16'd6, 1'b1);
    chk("t5_pending", pending_o[3], 1'b1);
    cfg_chan_i = 2'd3;
    cfg_period_i = 16'd0;
    cfg_enable_i = 1'b0;
    cfg_valid_i = 1'b1;
    #1;
    chk("t5_held_ready", cfg_ready_o, 1'b0);
    step();
    chk("t5_old_tick", tick_o[3], 1'b1);
    chk("t5_still_held", cfg_ready_o, 1'b0);
    step();
    chk("t5_applied_pending", pending_o[3], 1'b0);
    chk("t5_still_active", active_o[3], 1'b1);
    chk("t5_ready", cfg_ready_o, 1'b1);
    step();
    cfg_valid_i = 1'b0;
    chk("t5_stop_active", active_o[3], 1'b0);
    chk("t5_stop_tick", tick_o[3], 1'b0);
    step();
    chk("t5_stop_tick2", tick_o[3], 1'b0);
    // T6: asynchronous reset between edges
    chk("t6_pre_active", active_o[1], 1'b1);
    #3 rst_i = 1'b1;
    #1;
    chk("t6_tick", tick_o, 4'h0);
    chk("t6_active", active_o, 4'h0);
    chk("t6_pending", pending_o, 4'h0);
    chk("t6_ready", cfg_ready_o, 1'b1);
    #2 rst_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_idle_k%0d", k), tick_o, 4'h0);
    end
    wr(2'd0, 16'd4, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t6_tick_k%0d", k), tick_o, (k % 4 == 3) ? 4'b0001 : 4'b0000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
